// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the EX->MEM stage: FSM states, RV32 funct3 codes, size/alignment/strobe helpers.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Access size comes from funct3[1:0]; anything not byte/half is treated as a word.
   function automatic logic is_byte(input logic [2:0] f3);
      return f3[1:0] == 2'b00;
   endfunction

   function automatic logic is_half(input logic [2:0] f3);
      return f3[1:0] == 2'b01;
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      if (is_byte(f3))      return 1'b0;
      else if (is_half(f3)) return off[0];
      else                  return off != 2'b00;
   endfunction

   function automatic logic [3:0] strobe4(input logic [2:0] f3, input logic [1:0] off);
      if (is_byte(f3))      return 4'b0001 << off;
      else if (is_half(f3)) return 4'b0011 << {off[1], 1'b0};
      else                  return 4'b1111;
   endfunction

endpackage

// File: rtl/stage_memory_access_load_extend.sv
// Load lane select plus sign/zero extension of the returned memory word.
// Latency: combinational.
// Backpressure: none.
module load_extend
   import mem_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // pick the addressed byte/half, then extend according to funct3
   always_comb begin
      lane_b = word[{offset, 3'b000} +: 8];
      lane_h = word[{offset[1], 4'b0000} +: 16];
      case (funct3)
         F3_B:    data = {{(XLEN-8){lane_b[7]}}, lane_b};
         F3_BU:   data = {{(XLEN-8){1'b0}}, lane_b};
         F3_H:    data = {{(XLEN-16){lane_h[15]}}, lane_h};
         F3_HU:   data = {{(XLEN-16){1'b0}}, lane_h};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/stage_memory_access.sv
// EX->MEM pipeline register with data-memory load/store access over a valid/ready request, valid response port.
// Latency: 1 cycle for non-memory/misaligned ops; memory ops complete the cycle after the response.
// Backpressure: stall held high from the cycle after capture of an aligned memory op through the response cycle.
module stage_memory_access
   import mem_stage_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int RES_SRC_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ex_valid,
   input  logic                  flush,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic [XLEN-1:0]       ex_alu_result,
   input  logic [XLEN-1:0]       ex_instr_addr_plus,
   input  logic [RES_SRC_W-1:0]  ex_result_src,
   input  logic                  ex_wr_enable,
   input  logic                  ex_mem_read,
   input  logic                  ex_mem_write,
   input  logic [2:0]            ex_funct3,
   input  logic [XLEN-1:0]       ex_store_data,
   output logic                  stall,
   output logic                  dmem_req_valid,
   input  logic                  dmem_req_ready,
   output logic [XLEN-1:0]       dmem_req_addr,
   output logic                  dmem_req_we,
   output logic [XLEN/8-1:0]     dmem_req_wstrb,
   output logic [XLEN-1:0]       dmem_req_wdata,
   input  logic                  dmem_rsp_valid,
   input  logic [XLEN-1:0]       dmem_rsp_rdata,
   output logic                  mem_valid,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic [XLEN-1:0]       mem_alu_result,
   output logic [XLEN-1:0]       mem_instr_addr_plus,
   output logic [RES_SRC_W-1:0]  mem_result_src,
   output logic                  mem_wr_enable,
   output logic [XLEN-1:0]       mem_read_data,
   output logic                  mem_misaligned
);

   state_e          state, state_nxt;
   logic            held_wr_enable, held_read, held_write;
   logic [2:0]      held_funct3;
   logic [XLEN-1:0] held_store_data;
   logic [XLEN-1:0] load_data;
   logic            capture, live, is_mem, misaligned, issue, in_req;

   // A new bundle is taken whenever no access is outstanding.
   assign capture    = (state == S_IDLE);
   assign live       = ex_valid & ~flush;
   assign is_mem     = ex_mem_read | ex_mem_write;
   assign misaligned = is_misaligned(ex_funct3, ex_alu_result[1:0]);
   assign issue      = live & is_mem & ~misaligned;
   assign in_req     = (state == S_REQ);
   assign stall      = (state != S_IDLE);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // next-state: IDLE -> REQ on issue, REQ -> RESP on accept, RESP -> IDLE on response
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (issue)          state_nxt = S_REQ;
         S_REQ:   if (dmem_req_ready) state_nxt = S_RESP;
         S_RESP:  if (dmem_rsp_valid) state_nxt = S_IDLE;
         default:                     state_nxt = S_IDLE;
      endcase
   end

   // request fields come from the held bundle and are only driven while the request is up
   always_comb begin
      dmem_req_valid = in_req;
      dmem_req_addr  = '0;
      dmem_req_we    = 1'b0;
      dmem_req_wstrb = '0;
      dmem_req_wdata = '0;
      if (in_req) begin
         dmem_req_addr = {mem_alu_result[XLEN-1:2], 2'b00};
         dmem_req_we   = held_write;
         if (held_write) begin
            dmem_req_wstrb[3:0] = strobe4(held_funct3, mem_alu_result[1:0]);
            for (int i = 0; i < XLEN/8; i++) begin
               if (is_byte(held_funct3))      dmem_req_wdata[8*i +: 8] = held_store_data[7:0];
               else if (is_half(held_funct3)) dmem_req_wdata[8*i +: 8] = held_store_data[8*(i%2) +: 8];
               else                           dmem_req_wdata[8*i +: 8] = held_store_data[8*i +: 8];
            end
         end
      end
   end

   load_extend #(.XLEN(XLEN)) u_load_extend (
      .word   (dmem_rsp_rdata),
      .offset (mem_alu_result[1:0]),
      .funct3 (held_funct3),
      .data   (load_data)
   );

   // bundle capture and completion; mem_valid is a one-cycle pulse per retired instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_valid           <= 1'b0;
         mem_rd              <= '0;
         mem_alu_result      <= '0;
         mem_instr_addr_plus <= '0;
         mem_result_src      <= '0;
         mem_read_data       <= '0;
         mem_misaligned      <= 1'b0;
         held_wr_enable      <= 1'b0;
         held_read           <= 1'b0;
         held_write          <= 1'b0;
         held_funct3         <= '0;
         held_store_data     <= '0;
      end else if (capture) begin
         mem_valid           <= live & ~issue;
         mem_rd              <= ex_rd;
         mem_alu_result      <= ex_alu_result;
         mem_instr_addr_plus <= ex_instr_addr_plus;
         mem_result_src      <= ex_result_src;
         mem_read_data       <= '0;
         mem_misaligned      <= live & is_mem & misaligned;
         held_wr_enable      <= ex_wr_enable;
         held_read           <= ex_mem_read;
         held_write          <= ex_mem_write;
         held_funct3         <= ex_funct3;
         held_store_data     <= ex_store_data;
      end else if (state == S_RESP && dmem_rsp_valid) begin
         mem_valid     <= 1'b1;
         mem_read_data <= (held_read & ~held_write) ? load_data : '0;
      end else begin
         mem_valid <= 1'b0;
      end
   end

   assign mem_wr_enable = held_wr_enable & mem_valid & ~mem_misaligned;

endmodule
